// File: rtl/dshot_pkg.sv
// Shared types and helpers for the DShot frame transmitter.
// A frame is 11 value bits, 1 telemetry bit and a 4-bit checksum, sent MSB first.
package dshot_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BIT,
      GAP
   } dshot_state_t;

   localparam int FRAME_BITS = 16;
   localparam int CRC_BITS   = 4;

   // XOR of the three nibbles of the 12-bit packet.
   // The bidirectional variant transmits the complement of that checksum.
   function automatic logic [CRC_BITS-1:0] dshot_crc(input logic [11:0] packet,
                                                     input logic        invert);
      logic [CRC_BITS-1:0] sum;
      sum = packet[3:0] ^ packet[7:4] ^ packet[11:8];
      dshot_crc = invert ? ~sum : sum;
   endfunction

endpackage

// File: rtl/dshot_tx.sv
// DShot frame transmitter for a single ESC line.
// Accepts an 11-bit value plus telemetry bit, builds a 16-bit frame and sends it
// as pulse-width-coded bits, followed by an idle gap before the next accept.
// Build option: define DSHOT_BIDIR_EN for the bidirectional-DShot transmit side
// (inverted line polarity, idle high, and inverted checksum).
module dshot_tx
   import dshot_pkg::*;
#(
   parameter int BIT_CYCLES = 83,
   parameter int T1H_CYCLES = 62,
   parameter int T0H_CYCLES = 31,
   parameter int GAP_CYCLES = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [10:0] cmd_value,
   input  logic        cmd_telem,
   output logic        dshot_out,
   output logic        busy,
   output logic        frame_done
);

`ifdef DSHOT_BIDIR_EN
   localparam logic IDLE_LEVEL = 1'b1;
   localparam logic CRC_INVERT = 1'b1;
`else
   localparam logic IDLE_LEVEL = 1'b0;
   localparam logic CRC_INVERT = 1'b0;
`endif
   localparam logic ACTIVE_LEVEL = ~IDLE_LEVEL;

   // One counter serves both the bit period and the gap, so it is sized for the longer.
   localparam int CNT_MAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] T1H      = CNT_W'(T1H_CYCLES);
   localparam logic [CNT_W-1:0] T0H      = CNT_W'(T0H_CYCLES);
   localparam logic [3:0]       IDX_MSB  = 4'(FRAME_BITS - 1);

   // Timing must leave a visible low (or high) tail in every bit and at least one gap cycle.
   if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES &&
         T1H_CYCLES < BIT_CYCLES && GAP_CYCLES >= 1)) begin : g_bad_timing
      $fatal(1, "dshot_tx: require 0 < T0H < T1H < BIT_CYCLES and GAP_CYCLES >= 1");
   end

   dshot_state_t          state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [3:0]            idx_q, idx_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [11:0]           packet;
   logic [CNT_W-1:0]      high_time;
   logic                  line_d;
   logic                  done_d;

   assign packet    = {cmd_value, cmd_telem};
   assign cmd_ready = (state_q == IDLE) && !rst;
   assign busy      = (state_q != IDLE);

   // Next-state logic: accept in IDLE, walk 16 bit periods in BIT, then count out the gap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      frame_d = frame_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               frame_d = {packet, dshot_crc(packet, CRC_INVERT)};
               idx_d   = IDX_MSB;
               cnt_d   = '0;
               state_d = BIT;
            end
         end
         BIT: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (idx_q == 4'd0) begin
                  state_d = GAP;
               end else begin
                  idx_d = idx_q - 4'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The line level is decoded from the next-state values so the registered output
   // goes active on the very first cycle after the accept edge.
   always_comb begin
      high_time = frame_d[idx_d] ? T1H : T0H;
      line_d    = IDLE_LEVEL;
      if (state_d == BIT && cnt_d < high_time) begin
         line_d = ACTIVE_LEVEL;
      end
   end

   // State, counters, latched frame and registered outputs; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         frame_q    <= '0;
         dshot_out  <= IDLE_LEVEL;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         frame_q    <= frame_d;
         dshot_out  <= line_d;
         frame_done <= done_d;
      end
   end

endmodule

// File: tb/tb_dshot_tx.sv
// Self-checking bench for dshot_tx using a frame scoreboard fed at each send
// and drained by a pulse-width decoder watching the ESC line.
`timescale 1ns/1ps
module tb_dshot_tx;

   localparam int BIT_CYCLES = 8;
   localparam int T1H_CYCLES = 6;
   localparam int T0H_CYCLES = 3;
   localparam int GAP_CYCLES = 4;
   localparam int LOW_CYCLES = 16 * BIT_CYCLES + GAP_CYCLES;

`ifdef DSHOT_BIDIR_EN
   localparam logic        IDLE_LVL = 1'b1;
   localparam logic        CRC_INV  = 1'b1;
   localparam logic [15:0] F_1046   = 16'h82C9;
   localparam logic [15:0] F_ZERO   = 16'h000F;
   localparam logic [15:0] F_MAX    = 16'hFFF0;
`else
   localparam logic        IDLE_LVL = 1'b0;
   localparam logic        CRC_INV  = 1'b0;
   localparam logic [15:0] F_1046   = 16'h82C6;
   localparam logic [15:0] F_ZERO   = 16'h0000;
   localparam logic [15:0] F_MAX    = 16'hFFFF;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [10:0] cmd_value = '0;
   logic        cmd_telem = 1'b0;
   logic        dshot_out;
   logic        busy;
   logic        frame_done;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          frames_seen = 0;
   logic [15:0] sb[$];

   int          mon_run = 0;
   int          mon_bits = 0;
   logic [15:0] mon_shift = '0;
   logic [15:0] mon_exp;

   dshot_tx #(
      .BIT_CYCLES(BIT_CYCLES),
      .T1H_CYCLES(T1H_CYCLES),
      .T0H_CYCLES(T0H_CYCLES),
      .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_value (cmd_value),
      .cmd_telem (cmd_telem),
      .dshot_out (dshot_out),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Reference frame for a command word, from the checksum definition.
   function automatic logic [15:0] exp_frame(input logic [10:0] v, input logic t);
      logic [11:0] p;
      logic [3:0]  c;
      p = {v, t};
      c = p[3:0] ^ p[7:4] ^ p[11:8];
      if (CRC_INV) c = ~c;
      return {p, c};
   endfunction

   // Line decoder: measures each active pulse, turns it into a bit and checks whole frames.
   always @(negedge clk) begin
      if (rst) begin
         mon_run  = 0;
         mon_bits = 0;
      end else if (dshot_out !== IDLE_LVL) begin
         mon_run++;
      end else if (mon_run > 0) begin
         checks++;
         if (mon_run != T1H_CYCLES && mon_run != T0H_CYCLES) begin
            failures++;
            $display("[TB] FAIL pulse_width: width=%0d required %0d or %0d", mon_run, T0H_CYCLES, T1H_CYCLES);
         end
         mon_shift = {mon_shift[14:0], (mon_run == T1H_CYCLES)};
         mon_run   = 0;
         mon_bits++;
         if (mon_bits == 16) begin
            mon_bits = 0;
            frames_seen++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("[TB] FAIL frame_unexpected: frame=0x%04h with no command pending", mon_shift);
            end else begin
               mon_exp = sb.pop_front();
               if (mon_shift !== mon_exp) begin
                  failures++;
                  $display("[TB] FAIL frame_value: frame=0x%04h required 0x%04h", mon_shift, mon_exp);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic send(input logic [10:0] v, input logic t, input logic [15:0] expf, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL send_ready: cmd_ready=%b required 1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_value = v;
      cmd_telem = t;
      sb.push_back(expf);
      @(negedge clk);
      acc       = cyc;
      cmd_valid = 1'b0;
      cmd_value = 11'($urandom);
      cmd_telem = 1'($urandom);
   endtask

   task automatic wait_done(input string name, input int acc);
      int n;
      n = 0;
      while (frame_done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (frame_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL %s_done_timeout: frame_done=%b after %0d cycles", name, frame_done, n);
      end else if (cyc - acc != LOW_CYCLES) begin
         failures++;
         $display("[TB] FAIL %s_done_latency: latency=%0d required %0d", name, cyc - acc, LOW_CYCLES);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL %s_scoreboard: pending=%0d required 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (dshot_out !== IDLE_LVL || busy !== 1'b0 || cmd_ready !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_hold: out=%b busy=%b ready=%b done=%b required %b 0 0 0",
                     dshot_out, busy, cmd_ready, frame_done, IDLE_LVL);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || dshot_out !== IDLE_LVL) begin
         failures++;
         $display("[TB] FAIL reset_release: ready=%b busy=%b out=%b required 1 0 %b",
                  cmd_ready, busy, dshot_out, IDLE_LVL);
      end
   endtask

   task automatic test_single();
      int acc;
      send(11'd1046, 1'b0, F_1046, acc);
      checks++;
      if (dshot_out !== ~IDLE_LVL || busy !== 1'b1 || cmd_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_first_cycle: out=%b busy=%b ready=%b required %b 1 0",
                  dshot_out, busy, cmd_ready, ~IDLE_LVL);
      end
      wait_done("single", acc);
   endtask

   task automatic test_edges();
      int acc;
      send(11'd0, 1'b0, F_ZERO, acc);
      wait_done("edge_zero", acc);
      send(11'd2047, 1'b1, F_MAX, acc);
      wait_done("edge_max", acc);
   endtask

   task automatic test_back_to_back();
      int n;
      int low;
      int seen0;
      seen0 = frames_seen;
      @(negedge clk);
      n = 0;
      while (!cmd_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b1;
      cmd_value = 11'd48;
      cmd_telem = 1'b0;
      sb.push_back(exp_frame(11'd48, 1'b0));
      @(negedge clk);
      cmd_value = 11'd2000;
      sb.push_back(exp_frame(11'd2000, 1'b0));
      low = 0;
      while (cmd_ready !== 1'b1 && low < 1000) begin
         low++;
         @(negedge clk);
      end
      checks++;
      if (low != LOW_CYCLES) begin
         failures++;
         $display("[TB] FAIL b2b_ready_low: low_cycles=%0d required %0d", low, LOW_CYCLES);
      end
      checks++;
      if (frame_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_done_coincident: frame_done=%b required 1", frame_done);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_done("b2b_second", cyc);
      for (int i = 0; i < 3 * LOW_CYCLES; i++) @(negedge clk);
      checks++;
      if (frames_seen - seen0 != 2 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_count: frames=%0d busy=%b required 2 0", frames_seen - seen0, busy);
      end
   endtask

   task automatic test_reset_midframe();
      int acc;
      int pulses;
      send(11'd1046, 1'b0, F_1046, acc);
      while (cyc < acc + 8 * BIT_CYCLES + 2) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      checks++;
      if (dshot_out !== IDLE_LVL || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_idle: out=%b busy=%b required %b 0", dshot_out, busy, IDLE_LVL);
      end
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 2 * LOW_CYCLES; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("[TB] FAIL midreset_done: pulses=%0d required 0", pulses);
      end
      send(11'd1046, 1'b0, F_1046, acc);
      wait_done("midreset_resend", acc);
   endtask

   initial begin
      $display("[TB] dshot_tx bench start");
      test_reset();
      test_single();
      test_edges();
      test_back_to_back();
      test_reset_midframe();
      for (int i = 0; i < 10; i++) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
